// File: rtl/pkt_cmd_scheduler.sv
// Packet command sequencer: issues size/MAC/ethertype/payload commands into the
// builder's command FIFO, paced by packet count, size sweep and inter-command gap.
module pkt_cmd_scheduler #(
    parameter int SIZE_W = 11,
    parameter int GAP_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [SIZE_W-1:0] cfg_size_min,
    input  logic [SIZE_W-1:0] cfg_size_max,
    input  logic [SIZE_W-1:0] cfg_size_step,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [47:0]       cfg_d_mac,
    input  logic [47:0]       cfg_s_mac,
    input  logic [15:0]       cfg_ethertype,
    input  logic [7:0]        cfg_payload,
    input  logic              cfg_payload_inc,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [SIZE_W-1:0] cmd_size,
    output logic [47:0]       cmd_d_mac,
    output logic [47:0]       cmd_s_mac,
    output logic [15:0]       cmd_ethertype,
    output logic [7:0]        cmd_payload,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  count_r;
    logic [SIZE_W-1:0] size_min_r;
    logic [SIZE_W-1:0] size_max_r;
    logic [SIZE_W-1:0] size_step_r;
    logic [GAP_W-1:0]  gap_r;
    logic              payload_inc_r;
    logic [GAP_W-1:0]  gap_cnt;

    logic              wr;
    logic [SIZE_W:0]   size_sum;
    logic [SIZE_W-1:0] size_next;
    logic [CNT_W-1:0]  sent_inc;
    logic              last_write;

    // Handshake: the FIFO accepts a command in every cycle where fifo_wr_en is
    // high; fifo_wr_en is only raised in ISSUE while fifo_full is low, and the
    // cmd_* fields are held stable for the whole time ISSUE waits on full.
    assign wr         = (state == ISSUE) && !fifo_full;
    assign fifo_wr_en = wr;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign state_dbg  = state;

    // Sweep sum is one bit wider so an overflow past SIZE_W still wraps to min.
    assign size_sum   = {1'b0, cmd_size} + {1'b0, size_step_r};
    assign sent_inc   = sent_count + CNT_W'(1);
    assign last_write = (count_r != '0) && (sent_inc == count_r);

    always_comb begin
        size_next = size_min_r;
        if (size_step_r != '0 && size_min_r < size_max_r) begin
            if (size_sum > {1'b0, size_max_r}) begin
                size_next = size_min_r;
            end else begin
                size_next = size_sum[SIZE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count_r       <= '0;
            size_min_r    <= '0;
            size_max_r    <= '0;
            size_step_r   <= '0;
            gap_r         <= '0;
            payload_inc_r <= 1'b0;
            gap_cnt       <= '0;
            cmd_size      <= '0;
            cmd_d_mac     <= '0;
            cmd_s_mac     <= '0;
            cmd_ethertype <= '0;
            cmd_payload   <= '0;
            sent_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // stop wins over a coincident start
                    if (start && !stop) begin
                        count_r       <= cfg_count;
                        size_min_r    <= cfg_size_min;
                        size_max_r    <= cfg_size_max;
                        size_step_r   <= cfg_size_step;
                        gap_r         <= cfg_gap;
                        payload_inc_r <= cfg_payload_inc;
                        cmd_size      <= cfg_size_min;
                        cmd_d_mac     <= cfg_d_mac;
                        cmd_s_mac     <= cfg_s_mac;
                        cmd_ethertype <= cfg_ethertype;
                        cmd_payload   <= cfg_payload;
                        sent_count    <= '0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr) begin
                        sent_count  <= sent_inc;
                        cmd_payload <= cmd_payload + {7'd0, payload_inc_r};
                        cmd_size    <= size_next;
                        if (stop) begin
                            state <= IDLE;
                        end else if (last_write) begin
                            state <= DONE;
                        end else if (gap_r != '0) begin
                            gap_cnt <= gap_r;
                            state   <= GAP;
                        end
                    end else if (stop) begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (gap_cnt <= GAP_W'(1)) begin
                        state <= ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_cmd_scheduler.sv
// Directed bench for pkt_cmd_scheduler: hand-computed command sequences are
// queued up front and matched against every FIFO write as it happens.
module tb_pkt_cmd_scheduler;

    localparam int SIZE_W = 11;
    localparam int GAP_W  = 16;
    localparam int CNT_W  = 32;
    localparam int W      = SIZE_W + 8;
    localparam logic [47:0] D_MAC = 48'h0011_2233_4455;
    localparam logic [47:0] S_MAC = 48'h66AA_BBCC_DDEE;
    localparam logic [15:0] ETYPE = 16'h88B5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [CNT_W-1:0]  cfg_count;
    logic [SIZE_W-1:0] cfg_size_min;
    logic [SIZE_W-1:0] cfg_size_max;
    logic [SIZE_W-1:0] cfg_size_step;
    logic [GAP_W-1:0]  cfg_gap;
    logic [47:0]       cfg_d_mac;
    logic [47:0]       cfg_s_mac;
    logic [15:0]       cfg_ethertype;
    logic [7:0]        cfg_payload;
    logic              cfg_payload_inc;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [SIZE_W-1:0] cmd_size;
    logic [47:0]       cmd_d_mac;
    logic [47:0]       cmd_s_mac;
    logic [15:0]       cmd_ethertype;
    logic [7:0]        cmd_payload;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent_count;
    logic [1:0]        state_dbg;

    pkt_cmd_scheduler #(.SIZE_W(SIZE_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_count(cfg_count), .cfg_size_min(cfg_size_min),
        .cfg_size_max(cfg_size_max), .cfg_size_step(cfg_size_step),
        .cfg_gap(cfg_gap), .cfg_d_mac(cfg_d_mac), .cfg_s_mac(cfg_s_mac),
        .cfg_ethertype(cfg_ethertype), .cfg_payload(cfg_payload),
        .cfg_payload_inc(cfg_payload_inc), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .cmd_size(cmd_size), .cmd_d_mac(cmd_d_mac),
        .cmd_s_mac(cmd_s_mac), .cmd_ethertype(cmd_ethertype),
        .cmd_payload(cmd_payload), .busy(busy), .done(done),
        .sent_count(sent_count), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // scoreboard
    logic [W-1:0] exp_q[$];
    int wr_cnt   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int wr_cyc_q[$];

    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (fifo_wr_en) begin
            exp_v = 'x;
            if (exp_q.size() > 0) exp_v = exp_q.pop_front();
            check("wr_cmd", {cmd_size, cmd_payload}, exp_v);
            wr_cnt++;
            wr_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // driver tasks
    int st_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [SIZE_W-1:0] s, input logic [7:0] p);
        exp_q.push_back({s, p});
    endtask

    task automatic start_run(input logic [CNT_W-1:0] count, input logic [SIZE_W-1:0] smin,
                             input logic [SIZE_W-1:0] smax, input logic [SIZE_W-1:0] step,
                             input logic [GAP_W-1:0] gap, input logic [7:0] pay, input logic inc);
        cfg_count       = count;
        cfg_size_min    = smin;
        cfg_size_max    = smax;
        cfg_size_step   = step;
        cfg_gap         = gap;
        cfg_payload     = pay;
        cfg_payload_inc = inc;
        start = 1'b1;
        tick();
        start = 1'b0;
        st_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, busy, 0);
    endtask

    task automatic wait_writes(input string tag, input int base, input int target, input int budget);
        int n = 0;
        while ((wr_cnt - base) < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_wait"}, wr_cnt - base, target);
    endtask

    int wr0, d0, drop_cyc;

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; fifo_full = 1'b0;
        cfg_count = '0; cfg_size_min = '0; cfg_size_max = '0; cfg_size_step = '0;
        cfg_gap = '0; cfg_payload = '0; cfg_payload_inc = 1'b0;
        cfg_d_mac = D_MAC; cfg_s_mac = S_MAC; cfg_ethertype = ETYPE;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_cmd", {cmd_size, cmd_payload, cmd_ethertype}, 0);
        check("rst_sent", sent_count, 0);
        rst_n = 1'b1;
        tick();

        // T1: fixed size, back-to-back, constant payload
        wr0 = wr_cnt; d0 = done_cnt;
        repeat (4) push_exp(11'd64, 8'hA5);
        start_run(4, 64, 64, 0, 0, 8'hA5, 1'b0);
        check("t1_dmac", cmd_d_mac, D_MAC);
        check("t1_smac_etype", {cmd_s_mac, cmd_ethertype}, {S_MAC, ETYPE});
        wait_idle("t1", 50);
        check("t1_writes", wr_cnt - wr0, 4);
        check("t1_latency", wr_cyc_q[wr0], st_cyc);
        check("t1_b2b", wr_cyc_q[wr0+3] - wr_cyc_q[wr0], 3);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_done_cyc", done_cyc, wr_cyc_q[wr0+3] + 1);
        check("t1_sent", sent_count, 4);

        // T2: size sweep with wrap, payload wrap; cfg edits and start mid-run ignored
        wr0 = wr_cnt; d0 = done_cnt;
        push_exp(60, 8'hFE); push_exp(80, 8'hFF); push_exp(100, 8'h00);
        push_exp(60, 8'h01); push_exp(80, 8'h02); push_exp(100, 8'h03);
        start_run(6, 60, 100, 20, 0, 8'hFE, 1'b1);
        cfg_size_min = 11'd5; cfg_payload = 8'h00; cfg_count = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t2", 50);
        check("t2_writes", wr_cnt - wr0, 6);
        check("t2_sent", sent_count, 6);
        check("t2_done_cnt", done_cnt - d0, 1);

        // T3: gap of 5 idle cycles; step set but min == max keeps size fixed
        wr0 = wr_cnt; d0 = done_cnt;
        push_exp(128, 8'h11); push_exp(128, 8'h12); push_exp(128, 8'h13);
        start_run(3, 128, 128, 7, 5, 8'h11, 1'b1);
        wait_idle("t3", 100);
        check("t3_writes", wr_cnt - wr0, 3);
        check("t3_gap1", wr_cyc_q[wr0+1] - wr_cyc_q[wr0], 6);
        check("t3_gap2", wr_cyc_q[wr0+2] - wr_cyc_q[wr0+1], 6);
        check("t3_done_cnt", done_cnt - d0, 1);

        // T4: FIFO full for 10 cycles after start
        wr0 = wr_cnt;
        fifo_full = 1'b1;
        push_exp(256, 8'h33); push_exp(256, 8'h33); push_exp(256, 8'h33);
        start_run(3, 256, 256, 0, 0, 8'h33, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_wr", fifo_wr_en, 0);
            check("t4_hold_cmd", {cmd_size, cmd_payload}, {11'd256, 8'h33});
            tick();
        end
        check("t4_no_sent", sent_count, 0);
        fifo_full = 1'b0;
        drop_cyc = cyc;
        wait_idle("t4", 50);
        check("t4_writes", wr_cnt - wr0, 3);
        check("t4_resume_cyc", wr_cyc_q[wr0], drop_cyc);
        check("t4_sent", sent_count, 3);

        // T5: continuous run with gap 2, stopped after the 7th write
        wr0 = wr_cnt; d0 = done_cnt;
        repeat (7) push_exp(200, 8'h40);
        start_run(0, 200, 200, 0, 2, 8'h40, 1'b0);
        wait_writes("t5", wr0, 7, 100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_idle", state_dbg, 0);
        check("t5_busy", busy, 0);
        check("t5_sent", sent_count, 7);
        repeat (4) tick();
        check("t5_no_more_wr", wr_cnt - wr0, 7);
        check("t5_no_done", done_cnt - d0, 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("t5_start_stop", busy, 0);
        push_exp(200, 8'h41); push_exp(200, 8'h41);
        start_run(2, 200, 200, 0, 0, 8'h41, 1'b0);
        check("t5_restart_sent", sent_count, 0);
        wait_idle("t5r", 50);
        check("t5_restart_done", sent_count, 2);

        // T6: reset asserted during GAP
        wr0 = wr_cnt;
        push_exp(100, 8'h77); push_exp(100, 8'h77);
        start_run(0, 100, 100, 0, 3, 8'h77, 1'b0);
        wait_writes("t6", wr0, 2, 100);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_en", fifo_wr_en, 0);
        check("t6_rst_busy", {busy, done}, 0);
        check("t6_rst_cmd", {cmd_size, cmd_payload, cmd_ethertype}, 0);
        check("t6_rst_mac", {cmd_d_mac, cmd_s_mac} == 96'd0, 1);
        check("t6_rst_sent", sent_count, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("t6_no_wr", wr_cnt - wr0, 2);
        push_exp(50, 8'h01);
        start_run(1, 50, 50, 0, 0, 8'h01, 1'b0);
        wait_idle("t6r", 50);
        check("t6_new_run", sent_count, 1);

        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
